conv_loop_ctrl: RTL and testbench

Loop scheduler that sequences the convolution processing datapath for one layer tile. It waits for weight loading to finish, then walks the co-group / ky / kx / wo-group / ci-group loop nest. Each step issues one buffer read strobe with its feature and weight depth addresses, and the block frames each kx pass with a line-end pulse and a pipeline-drain gap. It sits between the layer-level control registers and the processing top; its outputs drive the processing top's read, ky, compute-enable and line-end inputs.

---
 rtl/conv_loop_ctrl_pkg.sv | 23 ++
 rtl/conv_loop_ctrl_loop_cnt_nest.sv | 96 +++++++++
 rtl/conv_loop_ctrl.sv | 271 +++++++++++++++++++++++++++
 tb/tb_conv_loop_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_loop_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// conv_loop_ctrl_pkg
// Shared definitions for the convolution loop scheduler:
//   - state_e      : scheduler FSM states
//   - GAP_CYC_DEF  : default number of drain cycles after each kx pass
//   - GAP_CNT_W    : width of the drain-gap counter (covers 1..15 cycles)
//   - NUM_LEVELS   : depth of the co/ky/kx/wo/ci loop nest
// -----------------------------------------------------------------------------
package conv_loop_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOAD = 3'd1,
        ST_RUN       = 3'd2,
        ST_GAP       = 3'd3,
        ST_DONE      = 3'd4
    } state_e;

    localparam int GAP_CYC_DEF = 4;
    localparam int GAP_CNT_W   = 4;
    localparam int NUM_LEVELS  = 5;

endpackage : conv_loop_ctrl_pkg

// File: rtl/conv_loop_ctrl_loop_cnt_nest.sv
// -----------------------------------------------------------------------------
// loop_cnt_nest
// Five cascaded wrap counters forming the loop nest, innermost first:
// ci, wo, kx, ky, co. Level i steps when every inner level sits at its
// terminal count while the nest is stepped; each level wraps to 0 after
// reaching limit-1. The counters always hold the indices of the NEXT step
// to be issued, so the carry outputs describe the step being issued now.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   clr          synchronous clear of all levels (job start)
//   en           issue one step of the nest this cycle
//   ci_lim..     iteration counts per level (non-zero while stepping)
//   ci_cnt       ci index of the step being issued
//   ky_cnt       ky index of the step being issued
//   pass_carry   issued step is the last of its kx pass (ci and wo terminal)
//   final_carry  issued step is the last step of the whole nest
// -----------------------------------------------------------------------------
module loop_cnt_nest
    import conv_loop_ctrl_pkg::*;
#(
    parameter int DEPTHWIDTH = 9,
    parameter int KWIDTH     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    input  logic [DEPTHWIDTH-1:0] ci_lim,
    input  logic [DEPTHWIDTH-1:0] wo_lim,
    input  logic [KWIDTH-1:0]     kx_lim,
    input  logic [KWIDTH-1:0]     ky_lim,
    input  logic [DEPTHWIDTH-1:0] co_lim,
    output logic [DEPTHWIDTH-1:0] ci_cnt,
    output logic [KWIDTH-1:0]     ky_cnt,
    output logic                  pass_carry,
    output logic                  final_carry
);

    logic [DEPTHWIDTH-1:0] ci_r;
    logic [DEPTHWIDTH-1:0] wo_r;
    logic [KWIDTH-1:0]     kx_r;
    logic [KWIDTH-1:0]     ky_r;
    logic [DEPTHWIDTH-1:0] co_r;

    // bit 0 = ci level ... bit 4 = co level
    logic [NUM_LEVELS-1:0] tc_s;
    logic [NUM_LEVELS-1:0] carry_s;

    // Terminal-count detection and the ripple of carries up the nest.
    always_comb begin
        tc_s[0] = (ci_r == (ci_lim - DEPTHWIDTH'(1)));
        tc_s[1] = (wo_r == (wo_lim - DEPTHWIDTH'(1)));
        tc_s[2] = (kx_r == (kx_lim - KWIDTH'(1)));
        tc_s[3] = (ky_r == (ky_lim - KWIDTH'(1)));
        tc_s[4] = (co_r == (co_lim - DEPTHWIDTH'(1)));
        carry_s[0] = en & tc_s[0];
        for (int i = 1; i < NUM_LEVELS; i++) begin
            carry_s[i] = carry_s[i-1] & tc_s[i];
        end
    end

    // Wrap counters: each level advances on the carry from the level inside it.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ci_r <= '0;
            wo_r <= '0;
            kx_r <= '0;
            ky_r <= '0;
            co_r <= '0;
        end else begin
            if (en) begin
                ci_r <= tc_s[0] ? '0 : ci_r + DEPTHWIDTH'(1);
            end
            if (carry_s[0]) begin
                wo_r <= tc_s[1] ? '0 : wo_r + DEPTHWIDTH'(1);
            end
            if (carry_s[1]) begin
                kx_r <= tc_s[2] ? '0 : kx_r + KWIDTH'(1);
            end
            if (carry_s[2]) begin
                ky_r <= tc_s[3] ? '0 : ky_r + KWIDTH'(1);
            end
            if (carry_s[3]) begin
                co_r <= tc_s[4] ? '0 : co_r + DEPTHWIDTH'(1);
            end
        end
    end

    assign ci_cnt      = ci_r;
    assign ky_cnt      = ky_r;
    assign pass_carry  = carry_s[1];
    assign final_carry = carry_s[NUM_LEVELS-1];

endmodule : loop_cnt_nest

// File: rtl/conv_loop_ctrl.sv
// -----------------------------------------------------------------------------
// conv_loop_ctrl
// Loop scheduler for one convolution layer tile. After a start pulse it
// captures the tile configuration, waits for the weights to be resident,
// then walks the co / ky / kx / wo / ci nest issuing one buffer read per
// cycle. Each kx pass is followed by a one-cycle line-end pulse (first gap
// cycle) and GAP_CYC idle cycles that let the processing pipeline drain.
//
// Ports:
//   I_clk, I_rst            clock, synchronous active-high reset
//   I_start                 job start pulse (honoured only when idle)
//   I_load_done             weights resident (level)
//   I_kx_num, I_ky_num      kernel width / height in iterations
//   I_ciGroup, I_woGroup,
//   I_coGroup               ci / wo / co group counts
//   O_rd_dv                 read strobe, one per nest step
//   O_rd_fdepth             feature depth = wo*ciGroup + ci
//   O_rd_wdepth             weight depth  = pass_base + ci
//   O_ky                    ky index of the current pass
//   O_compute_en            high from first read until the job ends
//   O_line_end              pulse in the cycle after each pass's last read
//   O_busy                  scheduler not idle
//   O_done                  one-cycle job completion pulse
// All outputs are registered and reset to 0.
// -----------------------------------------------------------------------------
module conv_loop_ctrl
    import conv_loop_ctrl_pkg::*;
#(
    parameter int DEPTHWIDTH = 9,
    parameter int KWIDTH     = 4,
    parameter int GAP_CYC    = GAP_CYC_DEF
) (
    input  logic                  I_clk,
    input  logic                  I_rst,
    input  logic                  I_start,
    input  logic                  I_load_done,
    input  logic [KWIDTH-1:0]     I_kx_num,
    input  logic [KWIDTH-1:0]     I_ky_num,
    input  logic [DEPTHWIDTH-1:0] I_ciGroup,
    input  logic [DEPTHWIDTH-1:0] I_woGroup,
    input  logic [DEPTHWIDTH-1:0] I_coGroup,
    output logic                  O_rd_dv,
    output logic [DEPTHWIDTH-1:0] O_rd_fdepth,
    output logic [DEPTHWIDTH-1:0] O_rd_wdepth,
    output logic [KWIDTH-1:0]     O_ky,
    output logic                  O_compute_en,
    output logic                  O_line_end,
    output logic                  O_busy,
    output logic                  O_done
);

    state_e state_r;
    state_e next_state_s;

    // Configuration captured at the start cycle
    logic [KWIDTH-1:0]     kx_num_r;
    logic [KWIDTH-1:0]     ky_num_r;
    logic [DEPTHWIDTH-1:0] ci_group_r;
    logic [DEPTHWIDTH-1:0] wo_group_r;
    logic [DEPTHWIDTH-1:0] co_group_r;

    // Address generation state
    logic [DEPTHWIDTH-1:0] f_cnt_r;
    logic [DEPTHWIDTH-1:0] w_base_r;
    logic                  pass_last_r;
    logic                  job_last_r;
    logic [GAP_CNT_W-1:0]  gap_cnt_r;

    // Registered outputs
    logic                  rd_dv_r;
    logic [DEPTHWIDTH-1:0] rd_fdepth_r;
    logic [DEPTHWIDTH-1:0] rd_wdepth_r;
    logic [KWIDTH-1:0]     ky_r;
    logic                  compute_en_r;
    logic                  line_end_r;
    logic                  busy_r;
    logic                  done_r;

    logic                  capture_s;
    logic                  issue_s;
    logic                  empty_s;
    logic                  gap_last_s;
    logic [DEPTHWIDTH-1:0] ci_cnt_s;
    logic [KWIDTH-1:0]     ky_cnt_s;
    logic                  pass_carry_s;
    logic                  final_carry_s;

    // A zero in any captured count means there is nothing to issue.
    assign empty_s = (kx_num_r   == KWIDTH'(0))     ||
                     (ky_num_r   == KWIDTH'(0))     ||
                     (ci_group_r == DEPTHWIDTH'(0)) ||
                     (wo_group_r == DEPTHWIDTH'(0)) ||
                     (co_group_r == DEPTHWIDTH'(0));

    assign gap_last_s = (gap_cnt_r == GAP_CNT_W'(GAP_CYC - 1));

    loop_cnt_nest #(
        .DEPTHWIDTH (DEPTHWIDTH),
        .KWIDTH     (KWIDTH)
    ) u_nest (
        .clk         (I_clk),
        .rst         (I_rst),
        .clr         (capture_s),
        .en          (issue_s),
        .ci_lim      (ci_group_r),
        .wo_lim      (wo_group_r),
        .kx_lim      (kx_num_r),
        .ky_lim      (ky_num_r),
        .co_lim      (co_group_r),
        .ci_cnt      (ci_cnt_s),
        .ky_cnt      (ky_cnt_s),
        .pass_carry  (pass_carry_s),
        .final_carry (final_carry_s)
    );

    // Next-state logic. issue_s means "the next cycle shows a read", so the
    // registered read outputs line up with the RUN state.
    always_comb begin
        next_state_s = state_r;
        issue_s      = 1'b0;
        capture_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (I_start) begin
                    next_state_s = ST_WAIT_LOAD;
                    capture_s    = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT_LOAD: begin
                if (I_load_done) begin
                    if (empty_s) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_RUN;
                        issue_s      = 1'b1;
                    end
                end else begin
                    next_state_s = ST_WAIT_LOAD;
                end
            end
            ST_RUN: begin
                // pass_last_r marks the read shown this cycle as the pass's last
                if (pass_last_r) begin
                    next_state_s = ST_GAP;
                end else begin
                    next_state_s = ST_RUN;
                    issue_s      = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_last_s) begin
                    if (job_last_r) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_RUN;
                        issue_s      = 1'b1;
                    end
                end else begin
                    next_state_s = ST_GAP;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Configuration capture; inputs are not looked at again during the job.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            kx_num_r   <= '0;
            ky_num_r   <= '0;
            ci_group_r <= '0;
            wo_group_r <= '0;
            co_group_r <= '0;
        end else if (capture_s) begin
            kx_num_r   <= I_kx_num;
            ky_num_r   <= I_ky_num;
            ci_group_r <= I_ciGroup;
            wo_group_r <= I_woGroup;
            co_group_r <= I_coGroup;
        end
    end

    // Depth address generation: fdepth is a per-pass running count, wdepth is
    // the pass base plus ci; both wrap naturally at the register width.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            f_cnt_r     <= '0;
            w_base_r    <= '0;
            pass_last_r <= 1'b0;
            job_last_r  <= 1'b0;
            rd_fdepth_r <= '0;
            rd_wdepth_r <= '0;
            ky_r        <= '0;
        end else if (capture_s) begin
            f_cnt_r     <= '0;
            w_base_r    <= '0;
            pass_last_r <= 1'b0;
            job_last_r  <= 1'b0;
        end else if (issue_s) begin
            rd_fdepth_r <= f_cnt_r;
            rd_wdepth_r <= w_base_r + ci_cnt_s;
            ky_r        <= ky_cnt_s;
            pass_last_r <= pass_carry_s;
            job_last_r  <= final_carry_s;
            if (pass_carry_s) begin
                f_cnt_r  <= '0;
                w_base_r <= w_base_r + ci_group_r;
            end else begin
                f_cnt_r  <= f_cnt_r + DEPTHWIDTH'(1);
            end
        end
    end

    // Drain-gap cycle counter, running only while in GAP.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            gap_cnt_r <= '0;
        end else if (state_r == ST_GAP) begin
            gap_cnt_r <= gap_cnt_r + GAP_CNT_W'(1);
        end else begin
            gap_cnt_r <= '0;
        end
    end

    // Status/strobe outputs, registered from the next-state decision.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            rd_dv_r      <= 1'b0;
            line_end_r   <= 1'b0;
            done_r       <= 1'b0;
            busy_r       <= 1'b0;
            compute_en_r <= 1'b0;
        end else begin
            rd_dv_r    <= issue_s;
            line_end_r <= (state_r == ST_RUN) && pass_last_r;
            done_r     <= (next_state_s == ST_DONE);
            busy_r     <= (next_state_s != ST_IDLE);
            if (next_state_s == ST_IDLE) begin
                compute_en_r <= 1'b0;
            end else if (issue_s) begin
                compute_en_r <= 1'b1;
            end
        end
    end

    assign O_rd_dv      = rd_dv_r;
    assign O_rd_fdepth  = rd_fdepth_r;
    assign O_rd_wdepth  = rd_wdepth_r;
    assign O_ky         = ky_r;
    assign O_compute_en = compute_en_r;
    assign O_line_end   = line_end_r;
    assign O_busy       = busy_r;
    assign O_done       = done_r;

endmodule : conv_loop_ctrl

// File: tb/tb_conv_loop_ctrl.sv
// -----------------------------------------------------------------------------
// tb_conv_loop_ctrl
// Self-checking bench for conv_loop_ctrl: a table of jobs with hand-computed
// read/line-end/done/pass-base expectations, a cycle-by-cycle reference trace
// built from the loop-nest rules, randomized jobs, and reset/start corner
// sequences.
// -----------------------------------------------------------------------------
module tb_conv_loop_ctrl;

    localparam int DW  = 9;
    localparam int KW  = 4;
    localparam int GAP = 4;
    localparam int DMOD = 1 << DW;

    logic          I_clk = 1'b0;
    logic          I_rst;
    logic          I_start;
    logic          I_load_done;
    logic [KW-1:0] I_kx_num;
    logic [KW-1:0] I_ky_num;
    logic [DW-1:0] I_ciGroup;
    logic [DW-1:0] I_woGroup;
    logic [DW-1:0] I_coGroup;
    logic          O_rd_dv;
    logic [DW-1:0] O_rd_fdepth;
    logic [DW-1:0] O_rd_wdepth;
    logic [KW-1:0] O_ky;
    logic          O_compute_en;
    logic          O_line_end;
    logic          O_busy;
    logic          O_done;

    int checks = 0;
    int errors = 0;

    conv_loop_ctrl #(
        .DEPTHWIDTH (DW),
        .KWIDTH     (KW),
        .GAP_CYC    (GAP)
    ) dut (
        .I_clk        (I_clk),
        .I_rst        (I_rst),
        .I_start      (I_start),
        .I_load_done  (I_load_done),
        .I_kx_num     (I_kx_num),
        .I_ky_num     (I_ky_num),
        .I_ciGroup    (I_ciGroup),
        .I_woGroup    (I_woGroup),
        .I_coGroup    (I_coGroup),
        .O_rd_dv      (O_rd_dv),
        .O_rd_fdepth  (O_rd_fdepth),
        .O_rd_wdepth  (O_rd_wdepth),
        .O_ky         (O_ky),
        .O_compute_en (O_compute_en),
        .O_line_end   (O_line_end),
        .O_busy       (O_busy),
        .O_done       (O_done)
    );

    always #5 I_clk = ~I_clk;

    // Expected outputs for one cycle
    typedef struct {
        logic rd;
        int   fd;
        int   wd;
        int   ky;
        logic le;
        logic dn;
        logic bs;
        logic ce;
    } cyc_t;

    // One job with its hand-derived expectations
    typedef struct {
        string name;
        int kx, ky, ci, wo, co, wl;
        int reads, les, done_cyc, nb;
        int base [4];
    } vec_t;

    cyc_t exp_q[$];

    function automatic vec_t mk(input string nm, input int kx, input int ky, input int ci,
                                input int wo, input int co, input int wl, input int reads,
                                input int les, input int done_cyc, input int nb,
                                input int b0, input int b1, input int b2, input int b3);
        vec_t v;
        v.name = nm; v.kx = kx; v.ky = ky; v.ci = ci; v.wo = wo; v.co = co; v.wl = wl;
        v.reads = reads; v.les = les; v.done_cyc = done_cyc; v.nb = nb;
        v.base[0] = b0; v.base[1] = b1; v.base[2] = b2; v.base[3] = b3;
        return v;
    endfunction

    function automatic cyc_t zero_cyc();
        cyc_t c;
        c.rd = 1'b0; c.fd = 0; c.wd = 0; c.ky = 0;
        c.le = 1'b0; c.dn = 1'b0; c.bs = 1'b0; c.ce = 1'b0;
        return c;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference trace, cycle 1 = first cycle after the start edge. Built from
    // the loop-nest definition: passes in co/ky/kx order, wo*ci reads each,
    // GAP drain cycles with a line-end on the first, then one done cycle.
    task automatic build_model(input vec_t v);
        cyc_t c;
        int pass;
        exp_q.delete();
        for (int i = 0; i < v.wl; i++) begin
            c = zero_cyc(); c.bs = 1'b1; exp_q.push_back(c);
        end
        if (v.kx == 0 || v.ky == 0 || v.ci == 0 || v.wo == 0 || v.co == 0) begin
            c = zero_cyc(); c.dn = 1'b1; c.bs = 1'b1; exp_q.push_back(c);
        end else begin
            pass = 0;
            for (int co = 0; co < v.co; co++)
                for (int ky = 0; ky < v.ky; ky++)
                    for (int kx = 0; kx < v.kx; kx++) begin
                        for (int wo = 0; wo < v.wo; wo++)
                            for (int ci = 0; ci < v.ci; ci++) begin
                                c = zero_cyc();
                                c.rd = 1'b1; c.bs = 1'b1; c.ce = 1'b1; c.ky = ky;
                                c.fd = (wo * v.ci + ci) % DMOD;
                                c.wd = (pass * v.ci + ci) % DMOD;
                                exp_q.push_back(c);
                            end
                        for (int g = 0; g < GAP; g++) begin
                            c = zero_cyc();
                            c.le = (g == 0); c.bs = 1'b1; c.ce = 1'b1;
                            exp_q.push_back(c);
                        end
                        pass++;
                    end
            c = zero_cyc(); c.dn = 1'b1; c.bs = 1'b1; c.ce = 1'b1; exp_q.push_back(c);
        end
        c = zero_cyc(); exp_q.push_back(c);
    endtask

    // Start one job and compare every cycle against the trace; with rand_io,
    // start pulses and load_done toggles are thrown in while the job is busy.
    task automatic run_job(input vec_t v, input bit rand_io);
        int reads, les, done_at, n;
        logic prev_rd;
        int bases[$];
        cyc_t e;
        build_model(v);
        reads = 0; les = 0; done_at = -1; prev_rd = 1'b0;
        @(negedge I_clk);
        I_kx_num = KW'(v.kx); I_ky_num = KW'(v.ky);
        I_ciGroup = DW'(v.ci); I_woGroup = DW'(v.wo); I_coGroup = DW'(v.co);
        I_start = 1'b1;
        I_load_done = (v.wl == 1);
        n = exp_q.size();
        for (int k = 1; k <= n; k++) begin
            @(negedge I_clk);
            e = exp_q[k-1];
            chk($sformatf("%s c%0d flags(rd,le,dn,bs,ce)", v.name, k),
                {27'd0, O_rd_dv, O_line_end, O_done, O_busy, O_compute_en},
                {27'd0, e.rd, e.le, e.dn, e.bs, e.ce});
            if (e.rd) begin
                chk($sformatf("%s c%0d fdepth", v.name, k), 32'(O_rd_fdepth), e.fd);
                chk($sformatf("%s c%0d wdepth", v.name, k), 32'(O_rd_wdepth), e.wd);
                chk($sformatf("%s c%0d ky", v.name, k), 32'(O_ky), e.ky);
            end
            if (O_rd_dv === 1'b1) reads++;
            if (O_line_end === 1'b1) les++;
            if (O_done === 1'b1 && done_at < 0) done_at = k;
            if (O_rd_dv === 1'b1 && prev_rd !== 1'b1) bases.push_back(int'(O_rd_wdepth));
            prev_rd = O_rd_dv;
            if (k == 1) begin
                // config must already be captured; scramble it
                I_kx_num = KW'($urandom); I_ky_num = KW'($urandom);
                I_ciGroup = DW'($urandom); I_woGroup = DW'($urandom); I_coGroup = DW'($urandom);
            end
            I_start = (rand_io && k < n) ? ($urandom_range(0, 5) == 0) : 1'b0;
            if (k < v.wl) I_load_done = 1'b0;
            else if (k == v.wl || !rand_io) I_load_done = 1'b1;
            else I_load_done = 1'($urandom_range(0, 1));
        end
        I_start = 1'b0;
        I_load_done = 1'b1;
        chk({v.name, " read count"}, reads, v.reads);
        chk({v.name, " line_end count"}, les, v.les);
        chk({v.name, " done cycle"}, done_at, v.done_cyc);
        for (int i = 0; i < v.nb; i++) begin
            if (i < bases.size())
                chk($sformatf("%s pass base %0d", v.name, i), bases[i], v.base[i]);
            else
                chk($sformatf("%s pass base %0d missing", v.name, i), 32'hFFFF_FFFF, v.base[i]);
        end
    endtask

    vec_t tbl[6];

    initial begin
        vec_t v;
        int n;
        int kx, ky, ci, wo, co, wl, passes;
        bit empty;

        //           name      kx ky ci  wo co wl reads les  done nb bases
        tbl[0] = mk("small",    1, 1, 1,  1, 1, 1,    1,  1,    7, 1, 0,   0,   0,   0);
        tbl[1] = mk("full",     3, 2, 3,  2, 2, 1,   72, 12,  122, 4, 0,   3,   6,   9);
        tbl[2] = mk("loadgate", 1, 1, 2,  2, 1, 11,   4,  1,   20, 1, 0,   0,   0,   0);
        tbl[3] = mk("wrap",     3, 2, 200, 1, 1, 1, 1200, 6, 1226, 4, 0, 200, 400,  88);
        tbl[4] = mk("co0",      2, 2, 2,  2, 0, 1,    0,  0,    2, 0, 0,   0,   0,   0);
        tbl[5] = mk("ci0",      1, 1, 0,  1, 1, 3,    0,  0,    4, 0, 0,   0,   0,   0);

        I_rst = 1'b1; I_start = 1'b0; I_load_done = 1'b0;
        I_kx_num = '0; I_ky_num = '0; I_ciGroup = '0; I_woGroup = '0; I_coGroup = '0;
        repeat (3) @(posedge I_clk);
        @(negedge I_clk);
        chk("reset outputs", {O_rd_dv, O_rd_fdepth, O_rd_wdepth, O_ky, O_compute_en,
                              O_line_end, O_busy, O_done}, 32'd0);
        I_rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_job(tbl[i], i != 0);
        end

        // Reset while the 5th read of the full job is on the outputs
        @(negedge I_clk);
        I_kx_num = 4'd3; I_ky_num = 4'd2; I_ciGroup = 9'd3; I_woGroup = 9'd2; I_coGroup = 9'd2;
        I_start = 1'b1; I_load_done = 1'b1;
        @(negedge I_clk);
        I_start = 1'b0;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (O_rd_dv === 1'b1) n++;
            if (n == 5) break;
            @(negedge I_clk);
        end
        chk("rst reached 5th read", n, 5);
        I_rst = 1'b1;
        @(negedge I_clk);
        chk("rst mid-run outputs", {O_rd_dv, O_rd_fdepth, O_rd_wdepth, O_ky, O_compute_en,
                                    O_line_end, O_busy, O_done}, 32'd0);
        I_rst = 1'b0;
        run_job(tbl[1], 1'b0);

        // Randomized jobs against the reference trace
        for (int r = 0; r < 10; r++) begin
            kx = int'($urandom_range(0, 3));
            ky = int'($urandom_range(1, 3));
            ci = int'($urandom_range(0, 4));
            wo = int'($urandom_range(1, 3));
            co = int'($urandom_range(0, 2));
            wl = int'($urandom_range(1, 4));
            empty = (kx == 0 || ci == 0 || co == 0);
            passes = kx * ky * co;
            v = mk($sformatf("rnd%0d", r), kx, ky, ci, wo, co, wl,
                   empty ? 0 : passes * wo * ci,
                   empty ? 0 : passes,
                   empty ? wl + 1 : wl + passes * (wo * ci + GAP) + 1,
                   0, 0, 0, 0, 0);
            run_job(v, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_conv_loop_ctrl
